hazard_tracker: RTL and testbench

Hazard detection unit for the 5-stage RV32I pipeline: the producer side of the decode stage's forwarding-select inputs. It tracks the destination register, write-enable and load flag of every instruction in EX, MEM and WB. Each cycle it compares them against the decode stage's `rs1`/`rs2` and drives the `RAW_hazards` and `RAW_mem_wb_hazards` buses. It also stalls IF/DEC with a bubble on a load-use dependency and inserts a bubble on a taken-branch flush.

---
 rtl/hazard_pkg.sv | 29 ++
 rtl/raw_match.sv | 14 +
 rtl/hazard_tracker.sv | 116 +++++++++++
 tb/tb_hazard_tracker.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard tracker: the pipeline slot record,
// stage indices and bit positions inside the RAW_hazards bus.
package hazard_pkg;

   localparam int RA_W   = 5;
   localparam int NSTAGE = 3;

   localparam int EX  = 0;
   localparam int MEM = 1;
   localparam int WB  = 2;

   localparam int RAW_RS1_EX  = 3;
   localparam int RAW_RS2_EX  = 2;
   localparam int RAW_RS1_MEM = 1;
   localparam int RAW_RS2_MEM = 0;

   typedef struct packed {
      logic            valid;
      logic [RA_W-1:0] rd;
      logic            rf_wb;
      logic            is_load;
   } slot_t;

   // x0 is hard-wired to zero, so an rd of 0 never produces a value worth forwarding
   function automatic logic is_writer(input slot_t s);
      return s.valid & s.rf_wb & (s.rd != '0);
   endfunction

endpackage

// File: rtl/raw_match.sv
// Compares one in-flight pipeline slot against one decode source register.
module raw_match
   import hazard_pkg::*;
(
   input  slot_t           slot_i,
   input  logic [RA_W-1:0] rs_i,
   output logic            match_o,
   output logic            match_load_o
);

   assign match_o      = is_writer(slot_i) & (slot_i.rd == rs_i);
   assign match_load_o = match_o & slot_i.is_load;

endmodule

// File: rtl/hazard_tracker.sv
// RAW hazard / load-use stall unit tracking the EX, MEM and WB slots of the pipeline.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_tracker
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] dec_rs1,
   input  logic [REG_ADDR_W-1:0] dec_rs2,
   input  logic [REG_ADDR_W-1:0] dec_rd,
   input  logic                  dec_rf_wb,
   input  logic                  dec_mem_load,
   input  logic                  dec_valid,
   input  logic                  flush,
   output logic [3:0]            RAW_hazards,
   output logic [1:0]            RAW_mem_wb_hazards,
   output logic                  stall_dec,
`ifdef HAZARD_PERF_EN
   output logic [CNT_W-1:0]      stall_cycles,
   output logic [CNT_W-1:0]      fwd_events,
`endif
   output logic                  bubble_ex
);

   // The slot record is fixed-width, so the address width cannot be changed independently
   if (REG_ADDR_W != RA_W || CNT_W < 1) begin : g_bad_param
      $error("hazard_tracker: REG_ADDR_W must equal RA_W and CNT_W must be positive");
   end

   slot_t           slot_q [NSTAGE];
   slot_t           slot_d [NSTAGE];
   logic [RA_W-1:0] rs     [2];

   logic [NSTAGE-1:0] m_q  [2];
   logic [NSTAGE-1:0] ml_q [2];

   logic [1:0] ex_bit, mem_bit, load_use, load_wb_bit;

   assign rs[0] = dec_rs1;
   assign rs[1] = dec_rs2;

   for (genvar s = 0; s < 2; s++) begin : g_src
      for (genvar g = 0; g < NSTAGE; g++) begin : g_stage
         raw_match u_match (
            .slot_i       (slot_q[g]),
            .rs_i         (rs[s]),
            .match_o      (m_q[s][g]),
            .match_load_o (ml_q[s][g])
         );
      end

      assign ex_bit[s]      = m_q[s][EX]  & ~ml_q[s][EX];
      assign mem_bit[s]     = m_q[s][MEM] & ~ml_q[s][MEM];
      // A non-load EX producer shadows an older load in MEM, so forwarding from EX suffices
      assign load_use[s]    = ml_q[s][EX] | (ml_q[s][MEM] & ~ex_bit[s]);
      assign load_wb_bit[s] = ml_q[s][WB] & ~m_q[s][EX] & ~m_q[s][MEM];
   end

   always_comb begin
      RAW_hazards                     = '0;
      RAW_mem_wb_hazards              = '0;
      RAW_hazards[RAW_RS1_EX]         = dec_valid & ex_bit[0];
      RAW_hazards[RAW_RS2_EX]         = dec_valid & ex_bit[1];
      RAW_hazards[RAW_RS1_MEM]        = dec_valid & mem_bit[0];
      RAW_hazards[RAW_RS2_MEM]        = dec_valid & mem_bit[1];
      RAW_mem_wb_hazards[1]           = dec_valid & load_wb_bit[0];
      RAW_mem_wb_hazards[0]           = dec_valid & load_wb_bit[1];
      // Flush beats load-use: the dependent instruction is being killed anyway
      stall_dec = rst & dec_valid & ~flush & (|load_use);
      bubble_ex = rst & (stall_dec | flush);
   end

   always_comb begin
      slot_d[WB]          = slot_q[MEM];
      slot_d[MEM]         = slot_q[EX];
      slot_d[EX].valid    = dec_valid & ~bubble_ex;
      slot_d[EX].rd       = dec_rd;
      slot_d[EX].rf_wb    = dec_rf_wb;
      slot_d[EX].is_load  = dec_mem_load;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NSTAGE; i++) slot_q[i] <= '0;
      end else begin
         for (int i = 0; i < NSTAGE; i++) slot_q[i] <= slot_d[i];
      end
   end

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
   logic [CNT_W-1:0] fwd_events_q, fwd_events_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q + CNT_W'(stall_dec);
      fwd_events_d   = fwd_events_q + CNT_W'(|RAW_hazards);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cycles_q <= '0;
         fwd_events_q   <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         fwd_events_q   <= fwd_events_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign fwd_events   = fwd_events_q;
`endif

endmodule

// File: tb/tb_hazard_tracker.sv
// Self-checking bench for hazard_tracker: directed scenarios plus randomized traffic
// checked against a nearest-producer reference model.
module tb_hazard_tracker;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] dec_rs1, dec_rs2, dec_rd;
   logic       dec_rf_wb, dec_mem_load, dec_valid, flush;
   logic [3:0] RAW_hazards;
   logic [1:0] RAW_mem_wb_hazards;
   logic       stall_dec, bubble_ex;
`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cycles, fwd_events;
`endif

   int total = 0;
   int bad   = 0;

   // Reference pipeline: index 0 = EX, 1 = MEM, 2 = WB
   bit         mv  [3];
   logic [4:0] mrd [3];
   bit         mwb [3];
   bit         mld [3];
   logic [31:0] exp_stall_cnt, exp_fwd_cnt;

   always #5 clk = ~clk;

   hazard_tracker #(.REG_ADDR_W(5), .CNT_W(32)) dut (
      .clk                (clk),
      .rst                (rst),
      .dec_rs1            (dec_rs1),
      .dec_rs2            (dec_rs2),
      .dec_rd             (dec_rd),
      .dec_rf_wb          (dec_rf_wb),
      .dec_mem_load       (dec_mem_load),
      .dec_valid          (dec_valid),
      .flush              (flush),
      .RAW_hazards        (RAW_hazards),
      .RAW_mem_wb_hazards (RAW_mem_wb_hazards),
      .stall_dec          (stall_dec),
`ifdef HAZARD_PERF_EN
      .stall_cycles       (stall_cycles),
      .fwd_events         (fwd_events),
`endif
      .bubble_ex          (bubble_ex)
   );

   // Youngest in-flight instruction that writes rs, or -1
   function automatic int nearest(input logic [4:0] rs);
      if (rs == 5'd0) return -1;
      for (int s = 0; s < 3; s++)
         if (mv[s] && mwb[s] && mrd[s] == rs) return s;
      return -1;
   endfunction

   function automatic bit mem_fwd(input logic [4:0] rs);
      return (rs != 5'd0) && mv[1] && mwb[1] && (mrd[1] == rs) && !mld[1];
   endfunction

   task automatic model_out(output logic [3:0] raw, output logic [1:0] mw,
                            output logic st, output logic bb);
      bit e[2], m[2], lu[2], w[2];
      for (int k = 0; k < 2; k++) begin
         logic [4:0] r;
         int n;
         r = (k == 0) ? dec_rs1 : dec_rs2;
         n = nearest(r);
         e[k]  = (n == 0) && !mld[0];
         lu[k] = (n == 0 || n == 1) && mld[n];
         w[k]  = (n == 2) && mld[2];
         m[k]  = mem_fwd(r);
      end
      raw = dec_valid ? {e[0], e[1], m[0], m[1]} : 4'b0;
      mw  = dec_valid ? {w[0], w[1]} : 2'b0;
      st  = rst && dec_valid && !flush && (lu[0] || lu[1]);
      bb  = rst && (st || flush);
   endtask

   task automatic model_clear();
      for (int s = 0; s < 3; s++) mv[s] = 1'b0;
      exp_stall_cnt = '0;
      exp_fwd_cnt   = '0;
   endtask

   task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic wb, input logic ld, input logic fl);
      dec_valid    = v;
      dec_rs1      = r1;
      dec_rs2      = r2;
      dec_rd       = rd;
      dec_rf_wb    = wb;
      dec_mem_load = ld;
      flush        = fl;
   endtask

   task automatic tick();
      logic [3:0] raw;
      logic [1:0] mw;
      logic       st, bb;
      model_out(raw, mw, st, bb);
      if (rst) begin
         exp_stall_cnt += 32'(st);
         exp_fwd_cnt   += 32'(raw != 4'b0);
         for (int s = 2; s > 0; s--) begin
            mv[s] = mv[s-1]; mrd[s] = mrd[s-1]; mwb[s] = mwb[s-1]; mld[s] = mld[s-1];
         end
         mv[0] = dec_valid && !bb; mrd[0] = dec_rd; mwb[0] = dec_rf_wb; mld[0] = dec_mem_load;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      model_clear();
      drive(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      total++;
      if ({RAW_hazards, RAW_mem_wb_hazards, stall_dec, bubble_ex} !== 8'b0) begin
         bad++;
         $display("FAIL reset_hold: got %b required 00000000",
                  {RAW_hazards, RAW_mem_wb_hazards, stall_dec, bubble_ex});
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      total++;
      if ({RAW_hazards, RAW_mem_wb_hazards, stall_dec, bubble_ex} !== 8'b0) begin
         bad++;
         $display("FAIL reset_release: got %b required 00000000",
                  {RAW_hazards, RAW_mem_wb_hazards, stall_dec, bubble_ex});
      end
`ifdef HAZARD_PERF_EN
      total++;
      if (stall_cycles !== 32'd0 || fwd_events !== 32'd0) begin
         bad++;
         $display("FAIL reset_counters: got %0d/%0d required 0/0", stall_cycles, fwd_events);
      end
`endif
      tick();
   endtask

   task automatic test_fwd_ex_mem();
      idle(3);
      drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b1, 5'd5, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
      #2;
      total++;
      if (RAW_hazards !== 4'b1000 || stall_dec !== 1'b0) begin
         bad++;
         $display("FAIL fwd_ex: got raw=%b stall=%b required raw=1000 stall=0", RAW_hazards, stall_dec);
      end
      tick();
      drive(1'b1, 5'd5, 5'd0, 5'd12, 1'b0, 1'b0, 1'b0);
      #2;
      total++;
      if (RAW_hazards !== 4'b0010 || stall_dec !== 1'b0) begin
         bad++;
         $display("FAIL fwd_mem: got raw=%b stall=%b required raw=0010 stall=0", RAW_hazards, stall_dec);
      end
      tick();
   endtask

   task automatic test_load_use();
      idle(3);
      drive(1'b1, 5'd1, 5'd0, 5'd6, 1'b1, 1'b1, 1'b0);
      tick();
      drive(1'b1, 5'd0, 5'd6, 5'd10, 1'b1, 1'b0, 1'b0);
      #2;
      total++;
      if (stall_dec !== 1'b1 || bubble_ex !== 1'b1 || RAW_hazards !== 4'b0) begin
         bad++;
         $display("FAIL load_use_ex: got stall=%b bubble=%b raw=%b required 1 1 0000",
                  stall_dec, bubble_ex, RAW_hazards);
      end
      tick();
      #1;
      total++;
      if (stall_dec !== 1'b1 || bubble_ex !== 1'b1) begin
         bad++;
         $display("FAIL load_use_mem: got stall=%b bubble=%b required 1 1", stall_dec, bubble_ex);
      end
      tick();
      #1;
      total++;
      if (stall_dec !== 1'b0 || bubble_ex !== 1'b0 || RAW_mem_wb_hazards !== 2'b01) begin
         bad++;
         $display("FAIL load_use_wb: got stall=%b bubble=%b memwb=%b required 0 0 01",
                  stall_dec, bubble_ex, RAW_mem_wb_hazards);
      end
      tick();
   endtask

   task automatic test_x0();
      idle(3);
      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
      tick();
      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
      tick();
      #1;
      total++;
      if ({RAW_hazards, RAW_mem_wb_hazards, stall_dec, bubble_ex} !== 8'b0) begin
         bad++;
         $display("FAIL x0_never_matches: got %b required 00000000",
                  {RAW_hazards, RAW_mem_wb_hazards, stall_dec, bubble_ex});
      end
      tick();
   endtask

   task automatic test_flush();
      idle(3);
      drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
      tick();
      drive(1'b1, 5'd7, 5'd0, 5'd11, 1'b1, 1'b0, 1'b1);
      #2;
      total++;
      if (stall_dec !== 1'b0 || bubble_ex !== 1'b1) begin
         bad++;
         $display("FAIL flush_wins: got stall=%b bubble=%b required 0 1", stall_dec, bubble_ex);
      end
      tick();
      drive(1'b1, 5'd11, 5'd0, 5'd13, 1'b1, 1'b0, 1'b0);
      #2;
      total++;
      if (RAW_hazards !== 4'b0 || stall_dec !== 1'b0) begin
         bad++;
         $display("FAIL flush_killed: got raw=%b stall=%b required 0000 0", RAW_hazards, stall_dec);
      end
      tick();
   endtask

   task automatic test_both();
      idle(3);
      drive(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b1, 5'd8, 5'd0, 5'd14, 1'b1, 1'b0, 1'b0);
      #2;
      total++;
      if (RAW_hazards !== 4'b1010 || stall_dec !== 1'b0) begin
         bad++;
         $display("FAIL ex_and_mem: got raw=%b stall=%b required 1010 0", RAW_hazards, stall_dec);
      end
      tick();
   endtask

   task automatic test_reset_stall();
      idle(3);
      drive(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 1'b0);
      tick();
      drive(1'b1, 5'd6, 5'd0, 5'd15, 1'b1, 1'b0, 1'b0);
      #2;
      total++;
      if (stall_dec !== 1'b1) begin
         bad++;
         $display("FAIL pre_reset_stall: got %b required 1", stall_dec);
      end
      rst = 1'b0;
      model_clear();
      #1;
      total++;
      if (stall_dec !== 1'b0 || bubble_ex !== 1'b0) begin
         bad++;
         $display("FAIL async_reset_drop: got stall=%b bubble=%b required 0 0", stall_dec, bubble_ex);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      total++;
      if ({RAW_hazards, RAW_mem_wb_hazards, stall_dec, bubble_ex} !== 8'b0) begin
         bad++;
         $display("FAIL reset_restart_empty: got %b required 00000000",
                  {RAW_hazards, RAW_mem_wb_hazards, stall_dec, bubble_ex});
      end
`ifdef HAZARD_PERF_EN
      total++;
      if (stall_cycles !== 32'd0) begin
         bad++;
         $display("FAIL stall_cnt_after_reset: got %0d required 0", stall_cycles);
      end
`endif
      tick();
   endtask

   task automatic test_random();
      logic [3:0] raw;
      logic [1:0] mw;
      logic       st, bb;
      bit         held = 1'b0;
      idle(3);
      for (int i = 0; i < 600; i++) begin
         // A stalled instruction is re-presented unchanged
         if (!held)
            drive(($urandom_range(0, 99) < 85), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), ($urandom_range(0, 99) < 75),
                  ($urandom_range(0, 99) < 35), 1'b0);
         flush = ($urandom_range(0, 99) < 10);
         #2;
         model_out(raw, mw, st, bb);
         total++;
         if (RAW_hazards !== raw) begin
            bad++;
            $display("FAIL rand_raw[%0d]: got %b required %b", i, RAW_hazards, raw);
         end
         total++;
         if (RAW_mem_wb_hazards !== mw) begin
            bad++;
            $display("FAIL rand_memwb[%0d]: got %b required %b", i, RAW_mem_wb_hazards, mw);
         end
         total++;
         if (stall_dec !== st || bubble_ex !== bb) begin
            bad++;
            $display("FAIL rand_stall[%0d]: got stall=%b bubble=%b required %b %b",
                     i, stall_dec, bubble_ex, st, bb);
         end
         held = st;
         tick();
      end
`ifdef HAZARD_PERF_EN
      total++;
      if (stall_cycles !== exp_stall_cnt || fwd_events !== exp_fwd_cnt) begin
         bad++;
         $display("FAIL perf_counters: got %0d/%0d required %0d/%0d",
                  stall_cycles, fwd_events, exp_stall_cnt, exp_fwd_cnt);
      end
`endif
   endtask

   initial begin
      model_clear();
      for (int s = 0; s < 3; s++) begin
         mrd[s] = '0; mwb[s] = 1'b0; mld[s] = 1'b0;
      end
      test_reset();
      test_fwd_ex_mem();
      test_load_use();
      test_x0();
      test_flush();
      test_both();
      test_reset_stall();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
